// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and the cycles-per-bit helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_cpb(input int clk_freq, input int baud_freq);
    return clk_freq / baud_freq;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    if (mode == PAR_ODD) begin
      return ~^data;
    end else begin
      return ^data;
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a fall-through head: o_rd_data always shows the oldest entry,
// so the reader can consume it in the same cycle it asserts i_rd_en.
module uart_sync_fifo #(
  parameter int p_width = 8,
  parameter int p_depth = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [p_width-1:0]       i_wr_data,
  input  logic                     i_rd_en,
  output logic [p_width-1:0]       o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(p_depth):0] o_count
);

  localparam int AW = $clog2(p_depth);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic wr_fire, rd_fire;
  logic [p_width-1:0] mem_q [p_depth];

  assign o_full    = (count_q == cnt_t'(p_depth));
  assign o_empty   = (count_q == cnt_t'(0));
  assign o_count   = count_q;
  assign o_rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_fire  = i_wr_en && !o_full;
    rd_fire  = i_rd_en && !o_empty;
    wr_ptr_d = wr_ptr_q + ptr_t'(wr_fire);
    rd_ptr_d = rd_ptr_q + ptr_t'(rd_fire);
    count_d  = count_q + cnt_t'(wr_fire) - cnt_t'(rd_fire);
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= ptr_t'(0);
      rd_ptr_q <= ptr_t'(0);
      count_q  <= cnt_t'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset because the pointers define validity
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes queue in a small FIFO and are sent as
// start / 8 data LSB-first / optional parity / 1-2 stop bits on a registered o_tx.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int p_clk_freq   = 100_000_000,
  parameter int p_baud_freq  = 115_200,
  parameter int p_fifo_depth = 4,
  parameter int p_parity     = 0,
  parameter int p_stop_bits  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic                          o_tx,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(p_fifo_depth):0] o_fifo_count
);

  localparam int CPB = calc_cpb(p_clk_freq, p_baud_freq);
  localparam int BW  = $clog2(CPB);
  typedef logic [BW-1:0] baud_t;
  localparam baud_t      BAUD_LAST = baud_t'(CPB - 1);
  localparam logic [2:0] STOP_LAST = 3'(p_stop_bits - 1);

  logic [2:0] state_q, state_d;
  baud_t      baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       fifo_rd_en, fifo_full, fifo_empty;
  logic [7:0] fifo_rd_data;

  uart_sync_fifo #(
    .p_width (8),
    .p_depth (p_fifo_depth)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_tx_valid),
    .i_wr_data (i_tx_data),
    .i_rd_en   (fifo_rd_en),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (o_fifo_count)
  );

  assign bit_end    = (baud_q == baud_t'(0));
  assign o_tx_ready = !fifo_full;
  assign o_tx       = tx_q;
  assign o_tx_busy  = busy_q;
  assign o_tx_done  = done_q;

  // Frame sequencing: every bit lasts CPB cycles, counted down from BAUD_LAST
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    data_d     = data_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          data_d     = fifo_rd_data;
          state_d    = ST_START;
          baud_d     = BAUD_LAST;
          bit_d      = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!bit_end) begin
          baud_d = baud_q - baud_t'(1);
        end else begin
          state_d = ST_DATA;
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (!bit_end) begin
          baud_d = baud_q - baud_t'(1);
        end else if (bit_q == 3'd7) begin
          state_d = (p_parity != PAR_NONE) ? ST_PARITY : ST_STOP;
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
        end else begin
          baud_d = BAUD_LAST;
          bit_d  = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (!bit_end) begin
          baud_d = baud_q - baud_t'(1);
        end else begin
          state_d = ST_STOP;
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
        end
      end
      ST_STOP: begin
        if (!bit_end) begin
          baud_d = baud_q - baud_t'(1);
        end else if (bit_q != STOP_LAST) begin
          baud_d = BAUD_LAST;
          bit_d  = bit_q + 3'd1;
        end else if (!fifo_empty) begin
          // Chain straight into the next frame with no idle gap
          fifo_rd_en = 1'b1;
          data_d     = fifo_rd_data;
          state_d    = ST_START;
          baud_d     = BAUD_LAST;
          bit_d      = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are derived from next-state so they line up with the registered state
  always_comb begin
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_d];
      ST_PARITY: tx_d = parity_bit(data_d, p_parity);
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (bit_d == STOP_LAST) && (baud_d == baud_t'(0));
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= baud_t'(0);
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four instances (no parity, odd, even, two stop bits) at CPB=100,
// exact-timing frame vectors, burst/back-to-back, reset abort and a randomised stream.
module tb_uart_tx_buffered;

  localparam int CLK = 100_000_000;
  localparam int BAUD = 1_000_000;
  localparam int CPB = 100;
  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data  [ND];
  logic       tx_valid [ND];
  logic       tx_ready [ND];
  logic       tx_line  [ND];
  logic       tx_busy  [ND];
  logic       tx_done  [ND];
  logic [2:0] fifo_cnt [ND];

  int par_mode [ND] = '{0, 1, 2, 0};
  int stop_n   [ND] = '{1, 1, 1, 2};

  uart_tx_buffered #(.p_clk_freq(CLK), .p_baud_freq(BAUD), .p_fifo_depth(4), .p_parity(0), .p_stop_bits(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]), .o_tx_ready(tx_ready[0]),
    .o_tx(tx_line[0]), .o_tx_busy(tx_busy[0]), .o_tx_done(tx_done[0]), .o_fifo_count(fifo_cnt[0]));
  uart_tx_buffered #(.p_clk_freq(CLK), .p_baud_freq(BAUD), .p_fifo_depth(4), .p_parity(1), .p_stop_bits(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]), .o_tx_ready(tx_ready[1]),
    .o_tx(tx_line[1]), .o_tx_busy(tx_busy[1]), .o_tx_done(tx_done[1]), .o_fifo_count(fifo_cnt[1]));
  uart_tx_buffered #(.p_clk_freq(CLK), .p_baud_freq(BAUD), .p_fifo_depth(4), .p_parity(2), .p_stop_bits(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[2]), .i_tx_valid(tx_valid[2]), .o_tx_ready(tx_ready[2]),
    .o_tx(tx_line[2]), .o_tx_busy(tx_busy[2]), .o_tx_done(tx_done[2]), .o_fifo_count(fifo_cnt[2]));
  uart_tx_buffered #(.p_clk_freq(CLK), .p_baud_freq(BAUD), .p_fifo_depth(4), .p_parity(0), .p_stop_bits(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data[3]), .i_tx_valid(tx_valid[3]), .o_tx_ready(tx_ready[3]),
    .o_tx(tx_line[3]), .o_tx_busy(tx_busy[3]), .o_tx_done(tx_done[3]), .o_fifo_count(fifo_cnt[3]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    tx_data[d]  = b;
    tx_valid[d] = 1'b1;
    tick(1);
    tx_valid[d] = 1'b0;
  endtask

  // Cycle-exact line check starting on the first start-bit cycle; frame[k] is the level of bit k
  task automatic check_line(input int d, input logic [11:0] frame, input int nbits, input string tag);
    int miss;
    for (int k = 0; k < nbits; k++) begin
      miss = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_line[d] !== frame[k]) miss++;
        if (tx_busy[d] !== 1'b1) miss++;
        if (tx_done[d] !== logic'((k == nbits - 1) && (c == CPB - 1))) miss++;
        tick(1);
      end
      chk($sformatf("%s bit%0d bad-cycles", tag, k), miss, 0);
    end
  endtask

  task automatic check_frame(input int d, input logic [7:0] b, input int nbits, input logic [11:0] frame,
                             input string tag);
    send_byte(d, b);
    chk({tag, " count@1"}, int'(fifo_cnt[d]), 1);
    chk({tag, " tx@1"}, int'(tx_line[d]), 1);
    tick(1);
    chk({tag, " count@2"}, int'(fifo_cnt[d]), 0);
    check_line(d, frame, nbits, tag);
    chk({tag, " busy-after"}, int'(tx_busy[d]), 0);
    chk({tag, " tx-after"}, int'(tx_line[d]), 1);
    chk({tag, " done-after"}, int'(tx_done[d]), 0);
  endtask

  // Behavioural receiver: mid-bit sampling, parity/stop/done checks; gap = idle cycles before start
  task automatic rx_frame(input int d, output logic [7:0] b, output int gap, output int err);
    int w;
    logic p;
    w = 0;
    err = 0;
    b = 8'h00;
    while (tx_line[d] !== 1'b0 && w < 5000) begin
      tick(1);
      w++;
    end
    gap = w;
    if (w >= 5000) begin
      err = 99;
      return;
    end
    tick(CPB / 2);
    if (tx_line[d] !== 1'b0) err++;
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = tx_line[d];
    end
    if (par_mode[d] != 0) begin
      tick(CPB);
      p = (par_mode[d] == 1) ? ~^b : ^b;
      if (tx_line[d] !== p) err++;
    end
    for (int s = 0; s < stop_n[d]; s++) begin
      tick(CPB);
      if (tx_line[d] !== 1'b1) err++;
    end
    tick(CPB / 2 - 1);
    if (tx_done[d] !== 1'b1) err++;
    tick(1);
    if (tx_done[d] !== 1'b0) err++;
  endtask

  typedef struct {
    int          dut;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] burst [6];
  logic [7:0] exp_q [$];
  logic [7:0] rb;
  int         gap, err, miss, t0, w;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      tx_valid[d] = 1'b0;
      tx_data[d]  = 8'h00;
    end
    vecs[0] = '{0, 8'hA5, 10, 12'h34A};
    vecs[1] = '{2, 8'hA5, 11, 12'h54A};
    vecs[2] = '{1, 8'h07, 11, 12'h40E};
    vecs[3] = '{1, 8'hA5, 11, 12'h74A};
    vecs[4] = '{3, 8'h00, 11, 12'h600};
    vecs[5] = '{3, 8'hFF, 11, 12'h7FE};
    vecs[6] = '{0, 8'h3C, 10, 12'h278};
    vecs[7] = '{2, 8'h01, 11, 12'h602};
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    tick(3);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst d%0d tx", d), int'(tx_line[d]), 1);
      chk($sformatf("rst d%0d ready", d), int'(tx_ready[d]), 1);
      chk($sformatf("rst d%0d busy", d), int'(tx_busy[d]), 0);
      chk($sformatf("rst d%0d done", d), int'(tx_done[d]), 0);
      chk($sformatf("rst d%0d count", d), int'(fifo_cnt[d]), 0);
    end
    rst = 1'b0;

    // Long idle after reset
    miss = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < ND; d++) begin
        if (tx_line[d] !== 1'b1 || tx_ready[d] !== 1'b1 || tx_busy[d] !== 1'b0 || fifo_cnt[d] !== 3'd0) miss++;
      end
      tick(1);
    end
    chk("idle bad-cycles", miss, 0);

    for (int i = 0; i < 8; i++) begin
      check_frame(vecs[i].dut, vecs[i].data, vecs[i].nbits, vecs[i].frame, $sformatf("vec%0d", i));
      tick(5);
    end

    // Two stop bits, back to back: stop level lasts exactly 200 cycles before the next start
    send_byte(3, 8'h00);
    send_byte(3, 8'hFF);
    check_line(3, 12'h600, 11, "stop2 f0");
    check_line(3, 12'h7FE, 11, "stop2 f1");
    chk("stop2 busy-after", int'(tx_busy[3]), 0);
    tick(5);

    // Burst: valid held high with six bytes, FIFO fills after five
    fork
      begin
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("burst ready@%0d", i), int'(tx_ready[0]), 1);
          tx_data[0]  = burst[i];
          tx_valid[0] = 1'b1;
          tick(1);
        end
        tx_data[0] = burst[5];
        chk("burst ready@5", int'(tx_ready[0]), 0);
        chk("burst count@5", int'(fifo_cnt[0]), 4);
        w = 0;
        while (tx_ready[0] !== 1'b1 && w < 3000) begin
          tick(1);
          w++;
        end
        chk("burst 6th accept cycle", cyc - t0, 1002);
        tick(1);
        tx_valid[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_frame(0, rb, gap, err);
          chk($sformatf("burst rx%0d err", i), err, 0);
          chk($sformatf("burst rx%0d byte", i), int'(rb), int'(burst[i]));
          chk($sformatf("burst rx%0d gap", i), gap, (i == 0) ? 2 : 0);
        end
      end
    join
    tick(5);

    // Reset in the middle of data bit 3 with two bytes still queued
    send_byte(0, 8'h81);
    send_byte(0, 8'h42);
    send_byte(0, 8'h24);
    tick(447);
    chk("abort count-before", int'(fifo_cnt[0]), 2);
    rst = 1'b1;
    tick(1);
    chk("abort tx", int'(tx_line[0]), 1);
    chk("abort count", int'(fifo_cnt[0]), 0);
    chk("abort busy", int'(tx_busy[0]), 0);
    rst = 1'b0;
    miss = 0;
    for (int c = 0; c < 3000; c++) begin
      if (tx_line[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_busy[0] !== 1'b0) miss++;
      tick(1);
    end
    chk("abort quiet bad-cycles", miss, 0);
    check_frame(0, 8'h5A, 10, 12'h2B4, "post-abort");
    tick(5);

    // Random stream on the odd-parity instance against a queue model
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          tick($urandom_range(0, 1400));
          tx_data[1]  = 8'($urandom);
          tx_valid[1] = 1'b1;
          w = 0;
          while (tx_ready[1] !== 1'b1 && w < 5000) begin
            tick(1);
            w++;
          end
          if (w >= 5000) chk("rand ready timeout", w, 0);
          exp_q.push_back(tx_data[1]);
          tick(1);
          tx_valid[1] = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          rx_frame(1, rb, gap, err);
          chk($sformatf("rand rx%0d err", i), err, 0);
          if (err == 99) break;
          if (exp_q.size() == 0) begin
            chk($sformatf("rand rx%0d unexpected", i), int'(rb), -1);
          end else begin
            chk($sformatf("rand rx%0d byte", i), int'(rb), int'(exp_q.pop_front()));
          end
        end
      end
    join
    chk("rand leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
